// File: rtl/risc_cpu_pkg.sv
// Shared widths, opcode encodings and FSM state type for the risc_cpu accumulator core.
package risc_cpu_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_STA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JZ  = 4'h7;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_e;

    // Opcodes whose EXEC cycle samples the operand from memory.
    function automatic logic reads_mem(input logic [3:0] op);
        return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
    endfunction

endpackage

// File: rtl/risc_cpu_if.sv
// Memory bus between the CPU (master) and its external 16-byte memory (slave).
interface risc_cpu_if;
    import risc_cpu_pkg::*;

    logic              read;
    logic              write;
    logic [DATA_W-1:0] memoryOut;
    logic [DATA_W-1:0] memoryIn;
    logic [ADDR_W-1:0] address;

    modport master (output read, output write, output memoryIn, output address, input memoryOut);
    modport slave  (input read, input write, input memoryIn, input address, output memoryOut);
endinterface

// File: rtl/risc_cpu_alu.sv
// Combinational ALU: produces the next accumulator value and carry/borrow for the current opcode.
module risc_cpu_alu
    import risc_cpu_pkg::*;
(
    input  logic [DATA_W-1:0] ac_i,
    input  logic [DATA_W-1:0] operand_i,
    input  logic [3:0]        opcode_i,
    output logic [DATA_W-1:0] result_o,
    output logic              carry_o
);

    always_comb begin
        result_o = ac_i;
        carry_o  = 1'b0;
        case (opcode_i)
            OP_LDA: result_o = operand_i;
            OP_ADD: {carry_o, result_o} = {1'b0, ac_i} + {1'b0, operand_i};
            OP_SUB: begin
                result_o = ac_i - operand_i;
                carry_o  = (operand_i > ac_i);
            end
            OP_AND: result_o = ac_i & operand_i;
            default: ;
        endcase
    end

endmodule

// File: rtl/risc_cpu.sv
// risc_cpu: 8-bit accumulator CPU, two-cycle FETCH/EXEC core with HALT.
// Define RISC_CPU_JZ_EN to enable the JZ (jump if AC==0) instruction; otherwise 0111 is a NOP.
//
//   state | meaning
//   FETCH | drive PC, latch instruction into IR, PC+1
//   EXEC  | drive IR[3:0], perform opcode, back to FETCH
//   HALT  | bus idle, hold all registers until clr
module risc_cpu
    import risc_cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 4'h0
) (
    input  logic       clk,
    input  logic       clr,
    risc_cpu_if.master mem_bus
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] ac_q, ac_d;
    logic              c_q, c_d;

    logic [3:0]        op;
    logic [ADDR_W-1:0] opnd_addr;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;
    logic [ADDR_W-1:0] addr;
    logic              rd;
    logic              wr;

    assign op        = ir_q[7:4];
    assign opnd_addr = ir_q[3:0];

`ifdef RISC_CPU_JZ_EN
    logic z;
    assign z = (ac_q == '0);
`endif

    risc_cpu_alu u_alu (
        .ac_i      (ac_q),
        .operand_i (mem_bus.memoryOut),
        .opcode_i  (op),
        .result_o  (alu_result),
        .carry_o   (alu_carry)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        ac_d    = ac_q;
        c_d     = c_q;
        addr    = pc_q;
        rd      = 1'b0;
        wr      = 1'b0;
        case (state_q)
            FETCH: begin
                rd      = 1'b1;
                ir_d    = mem_bus.memoryOut;
                pc_d    = pc_q + 4'd1;
                state_d = EXEC;
            end
            EXEC: begin
                addr    = opnd_addr;
                state_d = FETCH;
                rd      = reads_mem(op);
                if (rd) ac_d = alu_result;
                case (op)
                    OP_ADD, OP_SUB: c_d = alu_carry;
                    OP_STA:         wr = 1'b1;
                    OP_JMP:         pc_d = opnd_addr;
`ifdef RISC_CPU_JZ_EN
                    OP_JZ:          if (z) pc_d = opnd_addr;
`endif
                    OP_HLT:         state_d = HALT;
                    default: ;
                endcase
            end
            HALT: ;
            default: state_d = FETCH;
        endcase
    end

    // Write is gated by clr combinationally so a reset mid-STA never reaches memory.
    assign mem_bus.address  = addr;
    assign mem_bus.read     = rd;
    assign mem_bus.write    = wr & ~clr;
    assign mem_bus.memoryIn = ac_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            ac_q    <= '0;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ac_q    <= ac_d;
            c_q     <= c_d;
        end
    end

endmodule

// File: tb/tb_risc_cpu.sv
// Self-checking bench for risc_cpu: directed programs plus random programs against an ISA-level model.
`timescale 1ns/1ps
module tb_risc_cpu;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [7:0] mem [16];

    int errors = 0;
    int checks = 0;

    // ISA-level reference state
    int         m_pc, m_ac, m_c;
    bit         m_halt;
    logic [7:0] m_mem [16];

    risc_cpu_if bus ();

    risc_cpu dut (
        .clk     (clk),
        .clr     (clr),
        .mem_bus (bus)
    );

    assign bus.memoryOut = mem[bus.address];

    always #5 clk = ~clk;

    // Advance one cycle; memory stores what the DUT presented before the edge.
    task automatic tick();
        logic       w;
        logic [3:0] a;
        logic [7:0] d;
        w = bus.write;
        a = bus.address;
        d = bus.memoryIn;
        @(posedge clk);
        if (w === 1'b1) mem[a] = d;
        @(negedge clk);
    endtask

    task automatic begin_reset();
        clr = 1'b1;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    endtask

    task automatic model_reset();
        m_pc   = 0;
        m_ac   = 0;
        m_c    = 0;
        m_halt = 1'b0;
        for (int i = 0; i < 16; i++) m_mem[i] = mem[i];
    endtask

    task automatic end_reset();
        tick();
        tick();
        clr = 1'b0;
        model_reset();
    endtask

    // Run n steps (an instruction, or one idle cycle once halted), checking the bus every cycle.
    task automatic run_model(input string tag, input int n);
        logic [13:0] obs, exp;
        int          ir, op, a, operand, sum;
        bit          rd, wr;
        for (int s = 0; s < n; s++) begin
            if (m_halt) begin
                exp = {4'(m_pc), 1'b0, 1'b0, 8'(m_ac)};
                obs = {bus.address, bus.read, bus.write, bus.memoryIn};
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL %s halt step %0d: got addr=%h rd=%b wr=%b din=%h, expected addr=%h rd=%b wr=%b din=%h",
                             tag, s, obs[13:10], obs[9], obs[8], obs[7:0], exp[13:10], exp[9], exp[8], exp[7:0]);
                end
                tick();
            end else begin
                exp = {4'(m_pc), 1'b1, 1'b0, 8'(m_ac)};
                obs = {bus.address, bus.read, bus.write, bus.memoryIn};
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL %s fetch step %0d: got addr=%h rd=%b wr=%b din=%h, expected addr=%h rd=%b wr=%b din=%h",
                             tag, s, obs[13:10], obs[9], obs[8], obs[7:0], exp[13:10], exp[9], exp[8], exp[7:0]);
                end
                ir   = int'(m_mem[m_pc]);
                m_pc = (m_pc + 1) % 16;
                tick();
                op      = ir / 16;
                a       = ir % 16;
                operand = int'(m_mem[a]);
                rd      = (op == 1) || (op == 3) || (op == 4) || (op == 5);
                wr      = (op == 2);
                exp = {4'(a), rd, wr, 8'(m_ac)};
                obs = {bus.address, bus.read, bus.write, bus.memoryIn};
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL %s exec step %0d op=%0d: got addr=%h rd=%b wr=%b din=%h, expected addr=%h rd=%b wr=%b din=%h",
                             tag, s, op, obs[13:10], obs[9], obs[8], obs[7:0], exp[13:10], exp[9], exp[8], exp[7:0]);
                end
                tick();
                case (op)
                    1: m_ac = operand;
                    2: m_mem[a] = 8'(m_ac);
                    3: begin
                        sum  = m_ac + operand;
                        m_c  = (sum > 255) ? 1 : 0;
                        m_ac = sum % 256;
                    end
                    4: begin
                        m_c  = (operand > m_ac) ? 1 : 0;
                        m_ac = (m_ac - operand + 256) % 256;
                    end
                    5: m_ac = m_ac & operand;
                    6: m_pc = a;
`ifdef RISC_CPU_JZ_EN
                    7: if (m_ac == 0) m_pc = a;
`endif
                    15: m_halt = 1'b1;
                    default: ;
                endcase
            end
        end
    endtask

    task automatic test_reset();
        begin_reset();
        end_reset();
        checks++;
        if ({bus.address, bus.read, bus.write, bus.memoryIn} !== {4'h0, 1'b1, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL reset_bus: got addr=%h rd=%b wr=%b din=%h, expected addr=0 rd=1 wr=0 din=00",
                     bus.address, bus.read, bus.write, bus.memoryIn);
        end
        checks++;
        if (dut.c_q !== 1'b0) begin
            errors++;
            $display("FAIL reset_carry: got %b, expected 0", dut.c_q);
        end
    endtask

    task automatic test_load_add();
        begin_reset();
        mem[0] = 8'h1E; mem[1] = 8'h3F; mem[2] = 8'h2D; mem[3] = 8'hF0;
        mem[14] = 8'd5; mem[15] = 8'd7;
        end_reset();
        run_model("load_add", 6);
        checks++;
        if (mem[13] !== 8'd12) begin
            errors++;
            $display("FAIL load_add_m13: got %0d, expected 12", mem[13]);
        end
        checks++;
        if ({bus.read, bus.write, bus.address} !== {1'b0, 1'b0, 4'h4}) begin
            errors++;
            $display("FAIL load_add_halt: got rd=%b wr=%b addr=%h, expected rd=0 wr=0 addr=4",
                     bus.read, bus.write, bus.address);
        end
    endtask

    task automatic test_overflow();
        begin_reset();
        mem[0] = 8'h1E; mem[1] = 8'h3F; mem[2] = 8'h2D; mem[3] = 8'hF0;
        mem[14] = 8'd200; mem[15] = 8'd100;
        end_reset();
        run_model("add_ovf", 5);
        checks++;
        if ({mem[13], dut.c_q} !== {8'd44, 1'b1}) begin
            errors++;
            $display("FAIL add_overflow: got m13=%0d c=%b, expected m13=44 c=1", mem[13], dut.c_q);
        end
        begin_reset();
        mem[0] = 8'h1E; mem[1] = 8'h4F; mem[2] = 8'h2D; mem[3] = 8'hF0;
        mem[14] = 8'd3; mem[15] = 8'd5;
        end_reset();
        run_model("sub_borrow", 5);
        checks++;
        if ({mem[13], dut.c_q} !== {8'hFE, 1'b1}) begin
            errors++;
            $display("FAIL sub_borrow: got m13=%h c=%b, expected m13=fe c=1", mem[13], dut.c_q);
        end
    endtask

    task automatic test_write_timing();
        int         wcount;
        logic [3:0] waddr;
        logic [7:0] wdata;
        begin_reset();
        mem[0] = 8'h1E; mem[1] = 8'h2D; mem[2] = 8'hF0; mem[14] = 8'hA5;
        end_reset();
        wcount = 0;
        waddr  = 4'h0;
        wdata  = 8'h00;
        for (int i = 0; i < 10; i++) begin
            if (bus.write === 1'b1) begin
                wcount++;
                waddr = bus.address;
                wdata = bus.memoryIn;
            end
            tick();
        end
        checks++;
        if ({wcount[3:0], waddr, wdata} !== {4'd1, 4'hD, 8'hA5}) begin
            errors++;
            $display("FAIL write_timing: got count=%0d addr=%h data=%h, expected count=1 addr=d data=a5",
                     wcount, waddr, wdata);
        end
    endtask

    task automatic test_jmp_wrap();
        logic [3:0] exp_pc [6];
        logic [3:0] seen;
        exp_pc = '{4'h0, 4'h5, 4'h6, 4'h0, 4'h5, 4'h6};
        begin_reset();
        mem[0] = 8'h65; mem[5] = 8'h1F; mem[6] = 8'h60; mem[15] = 8'h42;
        end_reset();
        for (int i = 0; i < 6; i++) begin
            seen = bus.address;
            checks++;
            if (seen !== exp_pc[i]) begin
                errors++;
                $display("FAIL jmp_pc_seq[%0d]: got %h, expected %h", i, seen, exp_pc[i]);
            end
            tick();
            tick();
        end
        checks++;
        if (bus.memoryIn !== 8'h42) begin
            errors++;
            $display("FAIL jmp_ac: got %h, expected 42", bus.memoryIn);
        end
        begin_reset();
        end_reset();
        run_model("wrap", 18);
        checks++;
        if ({bus.address, bus.read} !== {4'h2, 1'b1}) begin
            errors++;
            $display("FAIL pc_wrap: got addr=%h rd=%b, expected addr=2 rd=1", bus.address, bus.read);
        end
    endtask

    task automatic test_jz();
        logic [3:0] exp_taken;
`ifdef RISC_CPU_JZ_EN
        exp_taken = 4'hA;
`else
        exp_taken = 4'h3;
`endif
        for (int k = 0; k < 2; k++) begin
            begin_reset();
            mem[0] = 8'h1E; mem[1] = 8'h79; mem[2] = 8'hF0; mem[9] = 8'hF0;
            mem[14] = (k == 0) ? 8'd0 : 8'd3;
            end_reset();
            run_model("jz", 4);
            checks++;
            if (bus.address !== ((k == 0) ? exp_taken : 4'h3)) begin
                errors++;
                $display("FAIL jz_case%0d: got halt pc=%h, expected %h", k, bus.address,
                         (k == 0) ? exp_taken : 4'h3);
            end
        end
    endtask

    task automatic test_reset_mid();
        begin_reset();
        mem[0] = 8'h1E; mem[1] = 8'h2D; mem[2] = 8'hF0;
        mem[13] = 8'h55; mem[14] = 8'h99;
        end_reset();
        tick(); tick(); tick();
        checks++;
        if ({bus.write, bus.address} !== {1'b1, 4'hD}) begin
            errors++;
            $display("FAIL sta_exec_write: got wr=%b addr=%h, expected wr=1 addr=d", bus.write, bus.address);
        end
        clr = 1'b1;
        #1;
        checks++;
        if (bus.write !== 1'b0) begin
            errors++;
            $display("FAIL clr_gates_write: got %b, expected 0", bus.write);
        end
        tick();
        tick();
        clr = 1'b0;
        checks++;
        if ({mem[13], bus.address, bus.read, bus.memoryIn} !== {8'h55, 4'h0, 1'b1, 8'h00}) begin
            errors++;
            $display("FAIL clr_mid_sta: got m13=%h addr=%h rd=%b ac=%h, expected m13=55 addr=0 rd=1 ac=00",
                     mem[13], bus.address, bus.read, bus.memoryIn);
        end
        model_reset();
        run_model("restart", 4);
        checks++;
        if (mem[13] !== 8'h99) begin
            errors++;
            $display("FAIL restart_sta: got %h, expected 99", mem[13]);
        end
        // clr from HALT reruns the program with new data
        clr = 1'b1;
        mem[14] = 8'h07;
        end_reset();
        run_model("halt_restart", 4);
        checks++;
        if (mem[13] !== 8'h07) begin
            errors++;
            $display("FAIL halt_restart: got %h, expected 07", mem[13]);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            begin_reset();
            for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
            end_reset();
            run_model("random", 24);
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (mem[i] !== m_mem[i]) begin
                    errors++;
                    $display("FAIL random%0d_mem[%0d]: got %h, expected %h", r, i, mem[i], m_mem[i]);
                end
            end
            checks++;
            if (dut.c_q !== 1'(m_c)) begin
                errors++;
                $display("FAIL random%0d_carry: got %b, expected %0d", r, dut.c_q, m_c);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        @(negedge clk);
        test_reset();
        test_load_add();
        test_overflow();
        test_write_timing();
        test_jmp_wrap();
        test_jz();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/risc_cpu.md
Name: risc_cpu

Overview:
- 8-bit accumulator CPU with a 4-bit address space (16 bytes).
- Memory is external to the block: reads are combinational (`memoryOut` follows `address` in the same cycle); writes happen at the memory on posedge `clk` while `write`=1.
- Instruction format: `opcode`=bits[7:4], operand address `a`=bits[3:0].
- Two-state multi-cycle core: FETCH then EXEC, plus a terminal HALT state.

Parameters:
- `RESET_PC`, 4'h0, value loaded into PC on reset.

Ports:
- `clk`  in  1  single system clock, all state updates on rising edge.
- `clr`  in  1  reset, synchronous, active-high.
- `read`  out  1  high when the CPU samples `memoryOut` this cycle.
- `write`  out  1  high when memory must store `memoryIn` at `address` on this posedge.
- `memoryOut`  in  8  data from memory at `address` (combinational).
- `memoryIn`  out  8  write data to memory; always equals AC.
- `address`  out  4  memory address.

Behaviour:
- Registers:
  - PC[3:0], IR[7:0], AC[7:0].
  - C: carry/borrow flag.
  - `state` in {FETCH, EXEC, HALT}.
  - Z is not a register: Z = (AC==0), combinational.
- Reset (`clr`=1 at posedge):
  - PC=`RESET_PC`, IR=0, AC=0, C=0, `state`=FETCH.
  - `write` is forced to 0 while `clr`=1 (combinational gate), so no memory corruption during reset.
  - `clr` overrides everything, including mid-instruction and HALT.
- FETCH:
  - Outputs: `address`=PC, `read`=1, `write`=0.
  - At posedge: IR<=`memoryOut`, PC<=PC+1 (mod 16, so 15 wraps to 0), `state`<=EXEC.
- EXEC:
  - Outputs: `address`=IR[3:0].
  - `read`=1 for LDA/ADD/SUB/AND, else 0.
  - `write`=1 only for STA.
  - At posedge, `state`<=FETCH unless HLT.
- Opcodes (apply at the EXEC posedge):
  - 0000 NOP: no change.
  - 0001 LDA a: AC<=M[a].
  - 0010 STA a: M[a]<=AC (memory performs the write); AC unchanged.
  - 0011 ADD a: {C,AC}<=AC+M[a], 9-bit sum, AC keeps the low 8 bits.
  - 0100 SUB a: AC<=AC-M[a] mod 256; C<=1 when M[a]>AC (borrow).
  - 0101 AND a: AC<=AC&M[a]; C unchanged.
  - 0110 JMP a: PC<=a.
  - 0111 JZ a: see Optional Feature.
  - 1111 HLT: `state`<=HALT.
  - All other opcodes execute as NOP.
- HALT: `read`=0, `write`=0, `address`=PC; no register changes until `clr`.
- Timing:
  - Every instruction takes exactly 2 cycles.
  - The first FETCH occurs in the first cycle after `clr` deasserts.
- Straight-line execution past address 15 wraps to 0.

Optional Feature:
- Macro: `RISC_CPU_JZ_EN`.
- Defined: opcode 0111 (JZ a) sets PC<=a when Z=1 at EXEC; otherwise no change.
- Undefined: opcode 0111 executes as NOP, with `read`=0 and `write`=0.

Decomposition:
- Package `risc_cpu_pkg`:
  - opcode constants (OP_NOP … OP_HLT);
  - `state` enum (FETCH, EXEC, HALT);
  - widths DATA_W=8, ADDR_W=4.
- One natural sub-module, `risc_cpu_alu`:
  - combinational;
  - inputs: AC, operand, opcode;
  - outputs: result[7:0], carry.
- Top level holds the FSM, registers and bus muxing.

Test Plan:
- Load-add program:
  - Memory: M0=0x1E (LDA 14), M1=0x3F (ADD 15), M2=0x2D (STA 13), M3=0xF0 (HLT), M14=5, M15=7.
  - Run 8 cycles after reset → M13=12, `state`=HALT, `read`=`write`=0 thereafter.
- Overflow:
  - Memory: LDA 14 / ADD 15 / STA 13 / HLT, with M14=200, M15=100.
  - Expected → M13=44, C=1.
  - Same program with SUB (M0=0x1E, M1=0x4F), M14=3, M15=5 → M13=0xFE, C=1.
- Write timing:
  - During the STA EXEC cycle, `write`=1 for exactly one cycle with `address`=IR[3:0] and `memoryIn`=AC.
  - `write`=0 in every FETCH cycle.
- JMP and wrap:
  - M0=0x65 (JMP 5), M5=0x1F (LDA 15), M6=0x60 (JMP 0).
  - Expected → PC sequence 0,5,6,0 repeating.
  - PC increment from 15 wraps to 0.
- JZ (with `RISC_CPU_JZ_EN` defined):
  - AC=0 then JZ 9 → PC=9.
  - AC=3 then JZ 9 → PC falls through.
  - Without the macro, JZ 9 with AC=0 → falls through.
- Reset mid-operation:
  - Assert `clr` during an EXEC of STA → `write`=0 in that cycle, memory unchanged.
  - After `clr` deasserts → PC=0, AC=0, fetch restarts from address 0.
  - `clr` asserted in HALT also restarts the program.
